// File: rtl/alu_multicycle.sv
// alu_multicycle: registered, handshaked execute unit for the MIPS core.
// Single-cycle logic/arith/shift ops complete one edge after acceptance.
// MULTU (shift-add) and DIVU (restoring) iterate one bit per cycle and
// write HI/LO only when the last step finishes.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   operand handshake (a, b, alu_op, shamt)
//   out_valid / out_ready result handshake (result, zero, overflow)
//   hi, lo                HI/LO registers, written only by MULTU/DIVU
module alu_multicycle #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3,
    OP_NOR = 4'd4, OP_SLT = 4'd5, OP_SLL = 4'd6, OP_SRL = 4'd7,
    OP_SRA = 4'd8, OP_SLTU = 4'd9, OP_XOR = 4'd10, OP_MULTU = 4'd11,
    OP_DIVU = 4'd12
  } op_e;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  state_e state, state_n;

  logic [WIDTH-1:0]   opd;      // multiplicand (MUL) or divisor (DIV)
  logic [2*WIDTH-1:0] acc;      // MUL: {partial, multiplier}; DIV: {rem, quotient}
  logic [SHW-1:0]     cnt;
  logic               last;
  logic               accept;

  logic [WIDTH-1:0]   alu_res, sum, dif;
  logic               alu_ovf;
  logic [WIDTH:0]     mul_sum, div_sh, div_trial;
  logic [2*WIDTH-1:0] mul_next, div_next;

  assign last   = (cnt == SHW'(WIDTH - 1));
  assign accept = in_valid && in_ready;

  // single-cycle ALU
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    sum     = a + b;
    dif     = a - b;
    case (alu_op)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = dif;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
      OP_SLL:  alu_res = b << shamt;
      OP_SRL:  alu_res = b >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(b) >>> shamt);
      OP_SLTU: alu_res = WIDTH'(a < b);
      OP_XOR:  alu_res = a ^ b;
      default: alu_res = '0;
    endcase
  end

  // one iteration of shift-add multiply / restoring divide
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : '0);
    mul_next  = {mul_sum, acc[WIDTH-1:1]};
    div_sh    = acc[2*WIDTH-1:WIDTH-1];
    div_trial = div_sh - {1'b0, opd};
    if (!div_trial[WIDTH])
      div_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      div_next = {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      MUL:  if (last) state_n = DONE;
      DIV:  if (last) state_n = DONE;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (accept) begin
      if (alu_op == OP_MULTU)                 state_n = MUL;
      else if (alu_op == OP_DIVU && b != '0)  state_n = DIV;
      else                                    state_n = DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      opd      <= '0;
      acc      <= '0;
      cnt      <= '0;
    end else if (accept) begin
      cnt <= '0;
      case (alu_op)
        OP_MULTU: begin
          opd <= a;
          acc <= {{WIDTH{1'b0}}, b};
        end
        OP_DIVU: begin
          if (b == '0) begin
            result   <= '1;
            zero     <= 1'b0;
            overflow <= 1'b0;
            lo       <= '1;
            hi       <= a;
          end else begin
            opd <= b;
            acc <= {{WIDTH{1'b0}}, a};
          end
        end
        default: begin
          result   <= alu_res;
          zero     <= (alu_res == '0);
          overflow <= alu_ovf;
        end
      endcase
    end else if (state == MUL || state == DIV) begin
      acc <= (state == MUL) ? mul_next : div_next;
      cnt <= cnt + 1'b1;
      if (last) begin
        hi       <= (state == MUL) ? mul_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
        lo       <= (state == MUL) ? mul_next[WIDTH-1:0] : div_next[WIDTH-1:0];
        result   <= (state == MUL) ? mul_next[WIDTH-1:0] : div_next[WIDTH-1:0];
        zero     <= ((state == MUL) ? mul_next[WIDTH-1:0] : div_next[WIDTH-1:0]) == '0;
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle at WIDTH=32.
module tb_alu_multicycle;
  logic        clk = 0, rst_n = 0;
  logic        in_valid = 0, in_ready, out_valid, out_ready = 0;
  logic [31:0] a = 0, b = 0, result, hi, lo;
  logic [3:0]  alu_op = 0;
  logic [4:0]  shamt = 0;
  logic        zero, overflow;
  int          vecs = 0, errs = 0;

  alu_multicycle #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_op(alu_op), .shamt(shamt), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .overflow(overflow),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // present one op for a single edge, then scramble the operands
  task automatic apply(input logic [3:0] op, input logic [31:0] va, vb, input logic [4:0] sh);
    alu_op = op; a = va; b = vb; shamt = sh; in_valid = 1;
    tick();
    in_valid = 0; a = 32'hDEADBEEF; b = 32'h12345678; alu_op = 4'd0; shamt = 5'd3;
  endtask

  // cycles from acceptance edge to out_valid; flags in_ready seen while busy
  task automatic wait_done(input int max, output int cyc, output bit rdy_seen);
    cyc = 1; rdy_seen = 0;
    while (!out_valid && cyc < max) begin
      if (in_ready) rdy_seen = 1;
      tick(); cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 0; tick(); tick(); tick();
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    vecs++; if ({result, hi, lo} !== 96'd0) begin errs++; $display("FAIL rst_regs got %h %h %h exp 0", result, hi, lo); end
    vecs++; if ({zero, overflow} !== 2'b00) begin errs++; $display("FAIL rst_flags got %b exp 00", {zero, overflow}); end
    rst_n = 1; tick();
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_single();
    logic [3:0]  t_op [12] = '{4'd0, 4'd1, 4'd1, 4'd8, 4'd5, 4'd9, 4'd14, 4'd2, 4'd3, 4'd4, 4'd10, 4'd6};
    logic [31:0] t_a  [12] = '{32'h7FFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                               32'd77, 32'hF0F01234, 32'hF0F01234, 32'hF0F01234, 32'hF0F01234, 32'd0};
    logic [31:0] t_b  [12] = '{32'd1, 32'd5, 32'd1, 32'h80000000, 32'd1, 32'd1,
                               32'd99, 32'h0FF0FF00, 32'h0FF0FF00, 32'h0FF0FF00, 32'h0FF0FF00, 32'd1};
    logic [4:0]  t_sh [12] = '{5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd31};
    logic [31:0] t_r  [12] = '{32'h80000000, 32'd0, 32'h7FFFFFFF, 32'hF8000000, 32'd1, 32'd0,
                               32'd0, 32'h00F01200, 32'hFFF0FF34, 32'h000F00CB, 32'hFF00ED34, 32'h80000000};
    logic        t_ov [12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int cyc; bit rs;
    out_ready = 1;
    for (int i = 0; i < 12; i++) begin
      apply(t_op[i], t_a[i], t_b[i], t_sh[i]);
      wait_done(4, cyc, rs);
      vecs++; if (cyc !== 1) begin errs++; $display("FAIL single_lat[%0d] got %0d exp 1", i, cyc); end
      vecs++; if (result !== t_r[i]) begin errs++; $display("FAIL single_res[%0d] got %h exp %h", i, result, t_r[i]); end
      vecs++; if (zero !== (t_r[i] == 0)) begin errs++; $display("FAIL single_zero[%0d] got %b exp %b", i, zero, t_r[i] == 0); end
      vecs++; if (overflow !== t_ov[i]) begin errs++; $display("FAIL single_ovf[%0d] got %b exp %b", i, overflow, t_ov[i]); end
      tick();
    end
    vecs++; if ({hi, lo} !== 64'd0) begin errs++; $display("FAIL single_hilo_hold got %h %h exp 0", hi, lo); end
  endtask

  task automatic test_multu();
    int cyc; bit rs;
    out_ready = 1;
    apply(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0);
    wait_done(40, cyc, rs);
    vecs++; if (cyc !== 33) begin errs++; $display("FAIL mul_lat got %0d exp 33", cyc); end
    vecs++; if (rs !== 1'b0) begin errs++; $display("FAIL mul_in_ready got 1 exp 0 while busy"); end
    vecs++; if (hi !== 32'hFFFFFFFE) begin errs++; $display("FAIL mul_hi got %h exp fffffffe", hi); end
    vecs++; if (lo !== 32'h1 || result !== 32'h1) begin errs++; $display("FAIL mul_lo got %h/%h exp 1", lo, result); end
    tick();
  endtask

  task automatic test_divu();
    int cyc; bit rs;
    out_ready = 1;
    apply(4'd12, 32'd100, 32'd7, 5'd0);
    wait_done(40, cyc, rs);
    vecs++; if (cyc !== 33) begin errs++; $display("FAIL div_lat got %0d exp 33", cyc); end
    vecs++; if (rs !== 1'b0) begin errs++; $display("FAIL div_in_ready got 1 exp 0 while busy"); end
    vecs++; if (lo !== 32'd14 || hi !== 32'd2) begin errs++; $display("FAIL div_hilo got %0d/%0d exp 2/14", hi, lo); end
    tick();
    apply(4'd12, 32'd9, 32'd0, 5'd0);
    wait_done(40, cyc, rs);
    vecs++; if (cyc !== 1) begin errs++; $display("FAIL div0_lat got %0d exp 1", cyc); end
    vecs++; if (lo !== 32'hFFFFFFFF || hi !== 32'd9) begin errs++; $display("FAIL div0_hilo got %h/%h exp 9/ffffffff", hi, lo); end
    vecs++; if (result !== 32'hFFFFFFFF || overflow !== 1'b0) begin errs++; $display("FAIL div0_res got %h ov %b exp ffffffff ov 0", result, overflow); end
    tick();
    apply(4'd0, 32'd10, 32'd20, 5'd0);
    vecs++; if (result !== 32'd30 || hi !== 32'd9 || lo !== 32'hFFFFFFFF) begin errs++; $display("FAIL hold_hilo got res %h hi %h lo %h exp 1e/9/ffffffff", result, hi, lo); end
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 0;
    apply(4'd0, 32'd3, 32'd4, 5'd0);
    for (int i = 0; i < 5; i++) begin
      vecs++; if (out_valid !== 1'b1 || result !== 32'd7 || zero !== 1'b0) begin errs++; $display("FAIL bp_stable[%0d] got v%b %h z%b exp v1 7 z0", i, out_valid, result, zero); end
      vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL bp_in_ready[%0d] got %b exp 0", i, in_ready); end
      tick();
    end
    out_ready = 1; in_valid = 1; alu_op = 4'd0;
    for (int k = 0; k < 8; k++) begin
      a = k * 16 + 1; b = k;
      #1;
      vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL b2b_ready[%0d] got %b exp 1", k, in_ready); end
      tick();
      vecs++; if (out_valid !== 1'b1 || result !== 32'(k * 17 + 1)) begin errs++; $display("FAIL b2b_res[%0d] got v%b %h exp v1 %h", k, out_valid, result, k * 17 + 1); end
    end
    in_valid = 0;
    tick();
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL b2b_drain got %b exp 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    int cyc; bit rs;
    out_ready = 1;
    apply(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0);
    for (int i = 0; i < 9; i++) tick();
    rst_n = 0; tick();
    vecs++; if (out_valid !== 1'b0 || {result, hi, lo} !== 96'd0) begin errs++; $display("FAIL mid_rst got v%b %h %h %h exp 0", out_valid, result, hi, lo); end
    vecs++; if ({zero, overflow} !== 2'b00) begin errs++; $display("FAIL mid_rst_flags got %b exp 00", {zero, overflow}); end
    rst_n = 1; tick();
    vecs++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errs++; $display("FAIL mid_release got r%b v%b exp r1 v0", in_ready, out_valid); end
    apply(4'd11, 32'd6, 32'd7, 5'd0);
    wait_done(40, cyc, rs);
    vecs++; if (cyc !== 33 || lo !== 32'd42 || hi !== 32'd0) begin errs++; $display("FAIL mid_fresh got cyc %0d hi %h lo %h exp 33/0/2a", cyc, hi, lo); end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_multu();
    test_divu();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
